// File: rtl/data_mem_sweep.sv
// Parametrised data memory: separate write/read ports, registered 1-cycle read
// with write-first forwarding, and an optional clear sweep after reset.
module data_mem_sweep #(
   parameter int          DW             = 8,
   parameter int          AW             = 8,
   parameter int          DEPTH          = 256,
   parameter int          CLEAR_ON_RESET = 1,
   parameter logic [DW-1:0] CLEAR_VAL    = '0
) (
   input  logic          Clk,
   input  logic          Reset,
   input  logic          WriteEn,
   input  logic [AW-1:0] WrAddr,
   input  logic [DW-1:0] WrData,
   input  logic          ReadEn,
   input  logic [AW-1:0] RdAddr,
   output logic [DW-1:0] DataOut,
   output logic          RdValid,
   output logic          Busy,
   output logic          ReqDrop
);

   localparam int PW = $clog2(DEPTH + 1);
   localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0]   DEPTH_W = (AW+1)'(DEPTH);
   localparam logic [PW-1:0] LAST    = PW'(DEPTH - 1);

   typedef enum logic {CLEAR, READY} state_t;

   state_t        state;
   logic [PW-1:0] ptr;
   logic [DW-1:0] core [DEPTH];

   logic wr_ok, rd_ok, fwd;

   // Range checks use one extra bit so DEPTH == 2**AW compares correctly.
   always_comb begin
      wr_ok = ({1'b0, WrAddr} < DEPTH_W);
      rd_ok = ({1'b0, RdAddr} < DEPTH_W);
      fwd   = WriteEn && wr_ok && (WrAddr == RdAddr);
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state   <= (CLEAR_ON_RESET != 0) ? CLEAR : READY;
         ptr     <= '0;
         DataOut <= '0;
         RdValid <= 1'b0;
         ReqDrop <= 1'b0;
         Busy    <= (CLEAR_ON_RESET != 0);
      end else begin
         case (state)
            CLEAR: begin
               core[ptr[IW-1:0]] <= CLEAR_VAL;
               ptr               <= ptr + 1'b1;
               RdValid           <= 1'b0;
               ReqDrop           <= WriteEn | ReadEn;
               if (ptr == LAST) begin
                  state <= READY;
                  Busy  <= 1'b0;
               end
            end
            default: begin
               ReqDrop <= 1'b0;
               Busy    <= 1'b0;
               if (WriteEn && wr_ok)
                  core[WrAddr[IW-1:0]] <= WrData;
               RdValid <= ReadEn;
               if (ReadEn) begin
                  if (!rd_ok)
                     DataOut <= '0;
                  else if (fwd)
                     DataOut <= WrData;
                  else
                     DataOut <= core[RdAddr[IW-1:0]];
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_data_mem_sweep.sv
// Directed bench for data_mem_sweep: default instance (A) and a DEPTH=200,
// CLEAR_VAL=8'hFF instance (B) exercised in turn.
module tb_data_mem_sweep;

   logic Clk = 1'b0;
   always #5 Clk = ~Clk;

   logic       ResetA = 1'b1, WeA = 1'b0, ReA = 1'b0;
   logic [7:0] WaA = '0, WdA = '0, RaA = '0;
   logic [7:0] DoA;
   logic       RvA, BusyA, DropA;

   logic       ResetB = 1'b1, WeB = 1'b0, ReB = 1'b0;
   logic [7:0] WaB = '0, WdB = '0, RaB = '0;
   logic [7:0] DoB;
   logic       RvB, BusyB, DropB;

   data_mem_sweep dut_a (
      .Clk(Clk), .Reset(ResetA), .WriteEn(WeA), .WrAddr(WaA), .WrData(WdA),
      .ReadEn(ReA), .RdAddr(RaA), .DataOut(DoA), .RdValid(RvA), .Busy(BusyA),
      .ReqDrop(DropA));

   data_mem_sweep #(.DW(8), .AW(8), .DEPTH(200), .CLEAR_ON_RESET(1), .CLEAR_VAL(8'hFF)) dut_b (
      .Clk(Clk), .Reset(ResetB), .WriteEn(WeB), .WrAddr(WaB), .WrData(WdB),
      .ReadEn(ReB), .RdAddr(RaB), .DataOut(DoB), .RdValid(RvB), .Busy(BusyB),
      .ReqDrop(DropB));

   typedef struct {
      bit         inst;   // 0 = A, 1 = B
      bit         we;
      logic [7:0] wa;
      logic [7:0] wd;
      bit         re;
      logic [7:0] ra;
      bit         exp_v;
      logic [7:0] exp_d;
   } vec_t;

   int nvec = 0;
   int nmis = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nmis++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge Clk);
      #1;
   endtask

   task automatic idle_inputs;
      WeA = 0; ReA = 0; WeB = 0; ReB = 0;
   endtask

   task automatic apply_vec(input vec_t v, input int idx);
      if (v.inst == 0) begin
         WeA = v.we; WaA = v.wa; WdA = v.wd; ReA = v.re; RaA = v.ra;
      end else begin
         WeB = v.we; WaB = v.wa; WdB = v.wd; ReB = v.re; RaB = v.ra;
      end
      tick();
      idle_inputs();
      if (v.inst == 0) begin
         check($sformatf("vecA[%0d] RdValid", idx), 32'(RvA), 32'(v.exp_v));
         check($sformatf("vecA[%0d] DataOut", idx), 32'(DoA), 32'(v.exp_d));
         check($sformatf("vecA[%0d] ReqDrop", idx), 32'(DropA), 32'd0);
      end else begin
         check($sformatf("vecB[%0d] RdValid", idx), 32'(RvB), 32'(v.exp_v));
         check($sformatf("vecB[%0d] DataOut", idx), 32'(DoB), 32'(v.exp_d));
         check($sformatf("vecB[%0d] ReqDrop", idx), 32'(DropB), 32'd0);
      end
   endtask

   vec_t va[$];
   vec_t vb[$];

   initial begin
      int n;

      // Instance A expectations after its sweep (array all zero, DataOut 0).
      va.push_back('{0, 0, 8'd0,   8'h00, 1, 8'd0,   1, 8'h00});
      va.push_back('{0, 0, 8'd0,   8'h00, 1, 8'd16,  1, 8'h00});
      va.push_back('{0, 0, 8'd0,   8'h00, 1, 8'd255, 1, 8'h00});
      va.push_back('{0, 0, 8'd200, 8'h00, 0, 8'd0,   0, 8'h00});  // no-op, hold
      va.push_back('{0, 0, 8'd0,   8'h00, 1, 8'd200, 1, 8'h00});  // dropped write
      va.push_back('{0, 1, 8'd16,  8'hA5, 0, 8'd0,   0, 8'h00});
      va.push_back('{0, 0, 8'd0,   8'h00, 1, 8'd16,  1, 8'hA5});
      va.push_back('{0, 0, 8'd0,   8'h00, 1, 8'd17,  1, 8'h00});
      va.push_back('{0, 1, 8'd244, 8'h05, 1, 8'd244, 1, 8'h05});  // write-first
      va.push_back('{0, 0, 8'd0,   8'h00, 0, 8'd0,   0, 8'h05});
      va.push_back('{0, 0, 8'd0,   8'h00, 1, 8'd244, 1, 8'h05});
      va.push_back('{0, 1, 8'd3,   8'h33, 1, 8'd16,  1, 8'hA5});  // independent
      va.push_back('{0, 0, 8'd0,   8'h00, 1, 8'd3,   1, 8'h33});
      va.push_back('{0, 1, 8'd255, 8'h9C, 0, 8'd0,   0, 8'h33});
      va.push_back('{0, 0, 8'd0,   8'h00, 1, 8'd255, 1, 8'h9C});

      // Instance B: DEPTH=200, CLEAR_VAL=FF.
      vb.push_back('{1, 1, 8'd250, 8'h11, 0, 8'd0,   0, 8'h00});
      vb.push_back('{1, 0, 8'd0,   8'h00, 1, 8'd250, 1, 8'h00});
      vb.push_back('{1, 0, 8'd0,   8'h00, 1, 8'd199, 1, 8'hFF});
      vb.push_back('{1, 0, 8'd0,   8'h00, 1, 8'd0,   1, 8'hFF});
      vb.push_back('{1, 1, 8'd5,   8'h12, 0, 8'd0,   0, 8'hFF});
      vb.push_back('{1, 0, 8'd0,   8'h00, 1, 8'd5,   1, 8'h12});
      vb.push_back('{1, 1, 8'd250, 8'h77, 1, 8'd250, 1, 8'h00});
      vb.push_back('{1, 1, 8'd200, 8'h44, 1, 8'd199, 1, 8'hFF});

      // ---- Instance A: reset and full sweep with a dropped request ----
      tick(); tick();
      check("A reset DataOut", 32'(DoA), 32'd0);
      check("A reset RdValid", 32'(RvA), 32'd0);
      check("A reset Busy",    32'(BusyA), 32'd1);
      check("A reset ReqDrop", 32'(DropA), 32'd0);
      ResetA = 0;
      n = 0;
      do begin
         tick();
         n++;
         if (n == 10) begin
            check("A drop pulse ReqDrop", 32'(DropA), 32'd1);
            check("A drop pulse RdValid", 32'(RvA), 32'd0);
            WeA = 0;
         end else if (n == 11) begin
            check("A drop pulse width", 32'(DropA), 32'd0);
         end
         if (n == 9) begin
            WeA = 1; WaA = 8'd200; WdA = 8'h77;
         end
      end while (BusyA && n < 1000);
      check("A sweep length", 32'(n), 32'd256);

      foreach (va[i]) apply_vec(va[i], i);

      // ---- Instance A: reset reasserted mid-sweep ----
      ResetA = 1; tick(); ResetA = 0;
      for (int i = 0; i < 100; i++) tick();
      check("A mid-sweep Busy", 32'(BusyA), 32'd1);
      ResetA = 1; ReA = 1; RaA = 8'd3;
      tick(); tick();
      ReA = 0;
      check("A re-reset DataOut", 32'(DoA), 32'd0);
      check("A re-reset RdValid", 32'(RvA), 32'd0);
      check("A re-reset ReqDrop", 32'(DropA), 32'd0);
      check("A re-reset Busy",    32'(BusyA), 32'd1);
      ResetA = 0;
      n = 0;
      do begin
         tick();
         n++;
      end while (BusyA && n < 1000);
      check("A restarted sweep length", 32'(n), 32'd256);
      apply_vec('{0, 0, 8'd0, 8'h00, 1, 8'd16,  1, 8'h00}, 100);
      apply_vec('{0, 0, 8'd0, 8'h00, 1, 8'd255, 1, 8'h00}, 101);

      // ---- Instance B ----
      ResetA = 1;
      tick();
      check("B reset Busy", 32'(BusyB), 32'd1);
      ResetB = 0;
      n = 0;
      do begin
         tick();
         n++;
      end while (BusyB && n < 1000);
      check("B sweep length", 32'(n), 32'd200);
      foreach (vb[i]) apply_vec(vb[i], i);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end

endmodule

// File: doc/data_mem_sweep.md
Name: data_mem_sweep

Overview:
- Parametrised successor to the single-pointer data memory.
- Separate write and read address ports, configurable data width and depth.
- Registered 1-cycle read with valid flag and write-first forwarding.
- Optional hardware clear sweep after reset, with a Busy handshake, so programs start from known contents without preload files.
- Sits between the core's load/store stage and the memory array.

Parameters:
- DW, 8, data width in bits.
- AW, 8, address width in bits.
- DEPTH, 256, number of words; must satisfy 1 <= DEPTH <= 2**AW.
- CLEAR_ON_RESET, 1, 1 = sweep CLEAR_VAL into every word after reset; 0 = contents untouched by reset.
- CLEAR_VAL, 0, DW-bit value written by the sweep.

Ports:
- Clk  in  1  clock; all state updates on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- WriteEn  in  1  write request this cycle.
- WrAddr  in  AW  write address.
- WrData  in  DW  write data.
- ReadEn  in  1  read request this cycle.
- RdAddr  in  AW  read address.
- DataOut  out  DW  registered read data.
- RdValid  out  1  DataOut holds the result of the read issued last cycle.
- Busy  out  1  clear sweep in progress; requests are not accepted.
- ReqDrop  out  1  one-cycle pulse: a request arrived while Busy and was discarded.

Behaviour:
- One clock (Clk); reset is synchronous, active-high (Reset), sampled only on the rising edge.
- FSM states: CLEAR and READY.
- While Reset=1 at an edge:
  - state <= CLEAR if CLEAR_ON_RESET=1, else READY.
  - sweep pointer <= 0.
  - DataOut <= 0, RdValid <= 0, ReqDrop <= 0.
  - Busy <= CLEAR_ON_RESET.
  - No array write occurs.
- CLEAR state (Reset=0):
  - Each edge writes Core[ptr] <= CLEAR_VAL, then ptr <= ptr+1.
  - The edge that writes ptr=DEPTH-1 moves state to READY and drives Busy <= 0.
  - Busy is therefore high for exactly DEPTH edges after Reset falls.
- Reset asserted mid-sweep: the sweep restarts from address 0. Already-cleared words stay cleared.
- Requests in CLEAR:
  - WriteEn and ReadEn are ignored; the array is not written and RdValid <= 0.
  - ReqDrop <= (WriteEn | ReadEn).
  - The caller must hold or retry requests until Busy=0.
- READY state writes: WriteEn=1 with WrAddr < DEPTH gives Core[WrAddr] <= WrData at the edge. WrAddr >= DEPTH: write discarded silently.
- READY state reads:
  - ReadEn=1 at edge N gives DataOut = Core[RdAddr] and RdValid=1 after edge N.
  - Latency is 1 cycle; back-to-back reads every cycle are supported.
  - RdAddr >= DEPTH returns 0, with RdValid=1.
- Read and write to the same address at the same edge (write-first): DataOut <= WrData and the array is updated. Different addresses: the two operate independently.
- ReadEn=0 at an edge: RdValid <= 0 and DataOut holds its previous value.
- ReqDrop is 0 in READY.
- Pointer width: ceil(log2(DEPTH+1)) bits, so no wrap occurs before the DEPTH-1 compare.
- Array contents are undefined after power-up when CLEAR_ON_RESET=0, until written.

Test Plan:
- Default params: Reset high 2 cycles then low → Busy=1 for exactly 256 cycles, then 0. Read of addresses 0, 16, 255 afterwards → DataOut=0, RdValid=1 one cycle after each ReadEn.
- After the sweep: write 8'hA5 to 16, then ReadEn with RdAddr=16 the next cycle → DataOut=8'hA5 one cycle later. Back-to-back reads of 16 and 17 on consecutive cycles → 8'hA5 then 8'h00 on consecutive cycles.
- Same-edge WriteEn(addr 244, data 5) and ReadEn(addr 244) → DataOut=5 next cycle. Core[244]=5 on a later read.
- During the sweep (cycle 10 after reset release), assert WriteEn(addr 200, data 8'h77) → ReqDrop=1 for one cycle, RdValid=0. After the sweep, Core[200]=0.
- Reset reasserted at sweep cycle 100 → pointer restarts; Busy stays high for 256 more cycles after release; all outputs are 0 during reset.
- DEPTH=200, AW=8, CLEAR_VAL=8'hFF: Busy high for 200 cycles. Write to 250 is discarded; read of 250 → 0 with RdValid=1; read of 199 → 8'hFF.
